// File: rtl/spi_master_param.sv
// Parameterised full-duplex SPI master: all four cpol/cpha modes, selectable bit
// order, runtime SCLK divider and NUM_CS active-low chip selects.
module spi_master_param #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 1,
  parameter int DIV_W  = 8,
  parameter int CS_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int EW = $clog2(2 * DATA_W + 1);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  cnt_r;
  logic [DIV_W-1:0]  div_r;
  logic [EW-1:0]     edge_r;
  logic              cpol_r;
  logic              cpha_r;
  logic              lsb_r;
  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] rx_r;

  logic tick_s;
  logic leading_s;
  logic sample_s;
  logic drive_s;

  function automatic logic first_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Received bits enter at the end that leaves the first bit at the same significance as on transmit.
  function automatic logic [DATA_W-1:0] insert_bit(input logic [DATA_W-1:0] w, input logic b,
                                                   input logic lsb);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] r;
    r = {NUM_CS{1'b1}};
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) r[i] = 1'b0;
    end
    return r;
  endfunction

  // Interval tick and classification of the SCLK edge the next tick would produce.
  always_comb begin
    tick_s    = (cnt_r == div_r);
    leading_s = ~edge_r[0];
    sample_s  = leading_s ^ cpha_r;
    if (cpha_r) begin
      drive_s = leading_s;
    end else begin
      drive_s = ~leading_s && (edge_r != (LAST_EDGE - EW'(1)));
    end
  end

  // Transfer sequencer with all SPI pins and handshake outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {DIV_W{1'b0}};
      div_r    <= {DIV_W{1'b0}};
      edge_r   <= {EW{1'b0}};
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      tx_r     <= {DATA_W{1'b0}};
      rx_r     <= {DATA_W{1'b0}};
      data_out <= {DATA_W{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= {NUM_CS{1'b1}};
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          sclk <= cpol;
          cs_n <= {NUM_CS{1'b1}};
          if (start) begin
            cpol_r  <= cpol;
            cpha_r  <= cpha;
            lsb_r   <= lsb_first;
            div_r   <= clk_div;
            cnt_r   <= {DIV_W{1'b0}};
            edge_r  <= {EW{1'b0}};
            rx_r    <= {DATA_W{1'b0}};
            busy    <= 1'b1;
            cs_n    <= cs_decode(cs_sel);
            state_r <= ST_SETUP;
            // In mode cpha=0 the first bit must already be on the wire before the leading edge.
            if (!cpha) begin
              mosi <= first_bit(data_in, lsb_first);
              tx_r <= shift_word(data_in, lsb_first);
            end else begin
              tx_r <= data_in;
            end
          end
        end
        ST_SETUP, ST_XFER: begin
          if (tick_s) begin
            cnt_r <= {DIV_W{1'b0}};
            if (edge_r == LAST_EDGE) begin
              state_r <= ST_HOLD;
            end else begin
              sclk    <= ~sclk;
              edge_r  <= edge_r + EW'(1);
              state_r <= ST_XFER;
              if (sample_s) rx_r <= insert_bit(rx_r, miso, lsb_r);
              if (drive_s) begin
                mosi <= first_bit(tx_r, lsb_r);
                tx_r <= shift_word(tx_r, lsb_r);
              end
            end
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        ST_HOLD: begin
          sclk <= cpol_r;
          if (tick_s) begin
            cnt_r    <= {DIV_W{1'b0}};
            cs_n     <= {NUM_CS{1'b1}};
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= rx_r;
            state_r  <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: directed table, random transfers against a
// cycle-timing reference model, back-to-back/ignored starts and reset mid-transfer.
module tb_spi_master_param;

  localparam int DW = 8;
  localparam int NE = 2 * DW;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] cs_sel;
  logic       cpol, cpha, lsb_first;
  logic [7:0] clk_div;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       busy, done, sclk, mosi, miso;
  logic [3:0] cs_n;
  logic       loop_en = 1'b0;
  logic       slave_bit = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] cs_sel;
    logic       cpol;
    logic       cpha;
    logic       lsb;
    logic [7:0] div;
    logic [7:0] din;
    logic [7:0] resp;
    logic       loop;
    int         junk_cyc;
    logic [7:0] exp_dout;
    int         exp_done;
  } xfer_t;

  xfer_t tbl[18];

  assign miso = loop_en ? mosi : slave_bit;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(8), .NUM_CS(4), .DIV_W(8), .CS_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha),
    .lsb_first(lsb_first), .clk_div(clk_div), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input xfer_t t);
    cs_sel    = t.cs_sel;
    cpol      = t.cpol;
    cpha      = t.cpha;
    lsb_first = t.lsb;
    clk_div   = t.div;
    data_in   = t.din;
  endtask

  function automatic xfer_t mk(input logic [2:0] cs, input logic cp, input logic ph, input logic lsb,
                               input logic [7:0] div, input logic [7:0] din, input logic [7:0] resp,
                               input logic loop);
    xfer_t t;
    t.cs_sel = cs; t.cpol = cp; t.cpha = ph; t.lsb = lsb; t.div = div;
    t.din = din; t.resp = resp; t.loop = loop; t.junk_cyc = 0;
    t.exp_dout = loop ? din : resp;
    t.exp_done = 1 + (int'(div) + 1) * (NE + 2);
    return t;
  endfunction

  // Bit the slave presents for the i-th transferred bit.
  function automatic logic resp_bit(input xfer_t t, input int i);
    return t.lsb ? t.resp[i] : t.resp[DW-1-i];
  endfunction

  task automatic run(input xfer_t t, input bit chain_in, input bit chain_out, input xfer_t nxt);
    int h, kv, k, idx, edges, bad_chg;
    logic prev_sclk, prev_mosi, edge_here, drive_edge;
    logic [7:0] mosi_rcv;
    logic [3:0] cs_exp;
    h = int'(t.div) + 1;
    edges = 0; bad_chg = 0; mosi_rcv = 8'h00;
    cs_exp = (t.cs_sel < 3'd4) ? ~(4'b0001 << t.cs_sel) : 4'hF;
    if (!chain_in) begin
      @(negedge clk);
      drive(t);
      start = 1'b1;
    end
    loop_en   = t.loop;
    slave_bit = resp_bit(t, 0);
    @(posedge clk);
    #1;
    start     = 1'b0;
    cs_sel    = 3'($urandom);
    cpol      = 1'($urandom);
    cpha      = 1'($urandom);
    lsb_first = 1'($urandom);
    clk_div   = 8'($urandom);
    data_in   = 8'($urandom);
    prev_sclk = t.cpol;
    prev_mosi = mosi;
    for (int n = 1; n <= t.exp_done; n++) begin
      @(negedge clk);
      kv = (n - 1) / h;
      if (kv > NE) kv = NE;
      if (sclk !== prev_sclk) edges++;
      chk($sformatf("sclk@%0d", n), sclk, t.cpol ^ kv[0]);
      chk($sformatf("cs_n@%0d", n), cs_n, (n < t.exp_done) ? cs_exp : 4'hF);
      chk($sformatf("busy@%0d", n), busy, (n < t.exp_done) ? 1'b1 : 1'b0);
      chk($sformatf("done@%0d", n), done, (n == t.exp_done) ? 1'b1 : 1'b0);
      if (n == 1 && !t.cpha) chk("first_mosi", mosi, t.lsb ? t.din[0] : t.din[7]);
      if (n >= 2 && n < t.exp_done && mosi !== prev_mosi) begin
        edge_here  = ((n - 1) % h == 0) && kv >= 1;
        drive_edge = t.cpha ? kv[0] : (!kv[0] && kv < NE);
        if (!(edge_here && drive_edge)) bad_chg++;
      end
      // The slave samples mosi where the master samples miso.
      if (n % h == 0 && n / h >= 1 && n / h <= NE) begin
        k = n / h;
        if (t.cpha ? !k[0] : k[0]) begin
          idx = (k - 1) / 2;
          mosi_rcv[t.lsb ? idx : DW - 1 - idx] = mosi;
        end
      end
      idx = t.cpha ? ((kv == 0) ? 0 : (kv - 1) / 2) : kv / 2;
      if (idx > DW - 1) idx = DW - 1;
      slave_bit = resp_bit(t, idx);
      if (n == t.junk_cyc) begin
        start   = 1'b1;
        data_in = 8'($urandom);
      end else if (n == t.junk_cyc + 1) begin
        start = 1'b0;
      end
      if (n == t.exp_done) begin
        chk("data_out", data_out, t.exp_dout);
        chk("edge_count", edges, NE);
        chk("mosi_stream", mosi_rcv, t.din);
        chk("mosi_on_drive_edges_only", bad_chg, 0);
        if (chain_out) begin
          drive(nxt);
          start = 1'b1;
        end
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
    end
  endtask

  initial begin
    xfer_t t, t2, none;
    logic [2:0] rcs;
    rst = 1'b1; start = 1'b0; cs_sel = 3'd0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; clk_div = 8'd0; data_in = 8'd0;
    none = mk(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0, 1'b0);

    tbl[0] = mk(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 8'h00, 1'b1);
    tbl[1] = mk(3'd1, 1'b0, 1'b0, 1'b0, 8'd3, 8'h96, 8'h3C, 1'b0);
    tbl[2] = mk(3'd1, 1'b0, 1'b1, 1'b0, 8'd3, 8'h96, 8'h3C, 1'b0);
    tbl[3] = mk(3'd1, 1'b1, 1'b0, 1'b0, 8'd3, 8'h96, 8'h3C, 1'b0);
    tbl[4] = mk(3'd1, 1'b1, 1'b1, 1'b0, 8'd3, 8'h96, 8'h3C, 1'b0);
    tbl[5] = mk(3'd0, 1'b0, 1'b0, 1'b1, 8'd0, 8'h01, 8'h00, 1'b1);
    tbl[6] = mk(3'd2, 1'b1, 1'b1, 1'b0, 8'd1, 8'h5A, 8'hC3, 1'b0);
    tbl[7] = mk(3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'h77, 8'h81, 1'b0);
    tbl[0].exp_done = 19;
    for (int i = 1; i <= 4; i++) tbl[i].exp_done = 73;
    for (int i = 8; i < 18; i++) begin
      rcs = 3'($urandom_range(0, 4));
      tbl[i] = mk(rcs, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom_range(0, 4)),
                  8'($urandom), 8'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_cs_n", cs_n, 4'hF);
    chk("rst_data_out", data_out, 8'h00);
    chk("rst_busy_done", {busy, done}, 2'b00);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) run(tbl[i], 1'b0, 1'b0, none);

    // Start pulsed mid-transfer is ignored; start in the done cycle chains the next transfer.
    t  = mk(3'd3, 1'b0, 1'b1, 1'b0, 8'd1, 8'hE4, 8'h1B, 1'b0);
    t.junk_cyc = 9;
    t2 = mk(3'd0, 1'b1, 1'b0, 1'b1, 8'd0, 8'h2D, 8'h00, 1'b1);
    run(t, 1'b0, 1'b1, t2);
    run(t2, 1'b1, 1'b0, none);

    // Reset in the middle of XFER.
    @(negedge clk);
    drive(mk(3'd1, 1'b1, 1'b0, 1'b0, 8'd0, 8'hF0, 8'h00, 1'b1));
    loop_en = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sclk", sclk, 1'b0);
    chk("midrst_mosi", mosi, 1'b0);
    chk("midrst_cs_n", cs_n, 4'hF);
    chk("midrst_data_out", data_out, 8'h00);
    chk("midrst_busy_done", {busy, done}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_done", done, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk("after_rst_quiet", {busy, done, cs_n}, 6'b001111);
    end
    run(tbl[1], 1'b0, 1'b0, none);
    run(tbl[0], 1'b0, 1'b0, none);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
